// File: rtl/crypto1_pkg.sv
// Shared types and default widths for the Crypto1 key search array and its
// result-collection controller.
package crypto1_pkg;

  localparam int unsigned CRYPTO1_KEY_W    = 48;
  localparam int unsigned CRYPTO1_STREAM_W = 48;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
    GRANT   = 3'd2,
    SHIFT   = 3'd3,
    PRESENT = 3'd4,
    ACK     = 3'd5,
    HOLD    = 3'd6,
    FINISH  = 3'd7
  } state_e;

endpackage

// File: rtl/crypto1_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after the
// pointer, wrapping at N.
module crypto1_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int unsigned  sum;
    logic [IW-1:0] jj;
    logic          found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = 0;
    jj    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = int'(ptr_i) + i;
      jj  = IW'((sum >= N) ? (sum - N) : sum);
      if (!found && req_i[jj]) begin
        found     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/crypto1_attack_ctrl.sv
// Result-collection controller for the Crypto1 search array: launches the
// cores, arbitrates their hits, shifts each winning key in serially and hands it on.
module crypto1_attack_ctrl
  import crypto1_pkg::*;
#(
  parameter int unsigned NCORES   = 256,
  parameter int unsigned KEY_W    = CRYPTO1_KEY_W,
  parameter int unsigned STREAM_W = CRYPTO1_STREAM_W,
  parameter bit          MODE_ALL = 1'b0,
  parameter int unsigned SRC_W    = $clog2(NCORES)
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                START,
  input  logic [STREAM_W-1:0] STREAM,
  output logic [STREAM_W-1:0] CORE_STREAM,
  output logic                CORE_RUN,
  input  logic [NCORES-1:0]   CORE_VALID,
  input  logic [NCORES-1:0]   CORE_DATA,
  input  logic [NCORES-1:0]   CORE_DONE,
  output logic                KEY_CLK,
  output logic [NCORES-1:0]   CORE_ACK,
  output logic [KEY_W-1:0]    KEY_OUT,
  output logic [SRC_W-1:0]    KEY_SRC,
  output logic                KEY_VALID,
  input  logic                KEY_READY,
  output logic                BUSY,
  output logic                DONE,
  output logic [7:0]          HIT_CNT
);

  localparam int unsigned   CW     = $clog2(2 * KEY_W);
  localparam logic [CW-1:0] C_LAST = CW'(2 * KEY_W - 1);

  state_e              state_q;
  logic [STREAM_W-1:0] stream_q;
  logic                run_q;
  logic                busy_q;
  logic                done_q;
  logic                kclk_q;
  logic                kvalid_q;
  logic [NCORES-1:0]   ack_q;
  logic [NCORES-1:0]   gnt_q;
  logic [KEY_W-1:0]    key_q,  key_d;
  logic [SRC_W-1:0]    src_q;
  logic [SRC_W-1:0]    ptr_q,  ptr_d;
  logic [7:0]          hit_q,  hit_d;
  logic [CW-1:0]       cnt_q;

  logic [NCORES-1:0]   arb_gnt;
  logic [SRC_W-1:0]    arb_idx;
  logic                arb_any;

  crypto1_rr_arbiter #(
    .N  (NCORES),
    .IW (SRC_W)
  ) u_arb (
    .req_i (CORE_VALID),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    key_d = {key_q[KEY_W-2:0], CORE_DATA[src_q]};
    hit_d = (hit_q == 8'hFF) ? hit_q : hit_q + 8'd1;
    ptr_d = (src_q == SRC_W'(NCORES - 1)) ? '0 : src_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q  <= IDLE;
      stream_q <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      kclk_q   <= 1'b0;
      kvalid_q <= 1'b0;
      ack_q    <= '0;
      gnt_q    <= '0;
      key_q    <= '0;
      src_q    <= '0;
      ptr_q    <= '0;
      hit_q    <= '0;
      cnt_q    <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE, FINISH: begin
          if (START) begin
            stream_q <= STREAM;
            hit_q    <= '0;
            ptr_q    <= '0;
            run_q    <= 1'b1;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            state_q  <= SEARCH;
          end
        end
        SEARCH: begin
          // A pending candidate wins over all-done seen in the same cycle.
          if (arb_any) begin
            src_q   <= arb_idx;
            gnt_q   <= arb_gnt;
            state_q <= GRANT;
          end else if (&CORE_DONE) begin
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        GRANT: begin
          cnt_q   <= '0;
          key_q   <= '0;
          kclk_q  <= 1'b0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          // Even counts sample the core's bit while KEY_CLK is low; odd counts
          // hold KEY_CLK high so the core advances to its next bit.
          if (!cnt_q[0]) begin
            key_q  <= key_d;
            kclk_q <= 1'b1;
          end else begin
            kclk_q <= 1'b0;
          end
          if (cnt_q == C_LAST) begin
            kvalid_q <= 1'b1;
            state_q  <= PRESENT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESENT: begin
          if (KEY_READY) begin
            kvalid_q <= 1'b0;
            hit_q    <= hit_d;
            ptr_q    <= ptr_d;
            ack_q    <= gnt_q;
            state_q  <= ACK;
          end
        end
        ACK: begin
          if (MODE_ALL) begin
            state_q <= HOLD;
          end else begin
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end
        HOLD: begin
          state_q <= SEARCH;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign CORE_STREAM = stream_q;
  assign CORE_RUN    = run_q;
  assign KEY_CLK     = kclk_q;
  assign CORE_ACK    = ack_q;
  assign KEY_OUT     = key_q;
  assign KEY_SRC     = src_q;
  assign KEY_VALID   = kvalid_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign HIT_CNT     = hit_q;

endmodule

// File: doc/crypto1_attack_ctrl.md
# crypto1_attack_ctrl

Parametrised result-collection controller for the Crypto1 key search array. It launches NCORES search cores on a latched keystream and arbitrates round-robin between cores reporting candidate keys. Each winning candidate is shifted in serially over the shared key clock and presented on a valid/ready output with its source core index. It either stops at the first hit or enumerates every hit until all cores report done.

## Interface
- NCORES, 256: number of attached search cores (≥2)
- KEY_W, 48: candidate key width in bits
- STREAM_W, 48: known keystream width
- MODE_ALL, 0: 0 = stop after first accepted key; 1 = collect every candidate until all cores done
- SRC_W, $clog2(NCORES): width of the core index
- CLK  in  1  clock
- RESETn  in  1  reset, synchronous, active-low
- START  in  1  launch search; accepted only in IDLE or FINISH
- STREAM  in  STREAM_W  known keystream; sampled on accepted START
- CORE_STREAM  out  STREAM_W  latched keystream broadcast to cores
- CORE_RUN  out  1  high from accepted START until FINISH
- CORE_VALID  in  NCORES  per-core "candidate held"; level, held until acked
- CORE_DATA  in  NCORES  per-core serial key bit, MSB first
- CORE_DONE  in  NCORES  per-core "search space exhausted"; level
- KEY_CLK  out  1  shared shift clock enable; each rising transition advances the granted core by one bit
- CORE_ACK  out  NCORES  one-hot, one-cycle pulse releasing the granted core
- KEY_OUT  out  KEY_W  captured candidate
- KEY_SRC  out  SRC_W  index of the core that produced KEY_OUT
- KEY_VALID  out  1  candidate available
- KEY_READY  in  1  consumer accepts the candidate
- BUSY  out  1  high in every state except IDLE and FINISH
- DONE  out  1  high in FINISH
- HIT_CNT  out  8  accepted candidates since START; saturates at 255

## Operation
- States: IDLE, SEARCH, GRANT, SHIFT, PRESENT, ACK, HOLD, FINISH.
- IDLE: on START, latch STREAM into CORE_STREAM, clear HIT_CNT, reset the round-robin pointer to 0, set CORE_RUN, go to SEARCH.
- SEARCH: if any CORE_VALID bit is set, the arbiter grants the first set bit at or after the pointer, wrapping at NCORES. Grant index goes to sel/KEY_SRC; go to GRANT. Otherwise, if &CORE_DONE, go to FINISH. CORE_VALID has priority over all-done in the same cycle.
- GRANT: clear the shift counter c and KEY_OUT. Go to SHIFT.
- SHIFT: c counts 0..2·KEY_W−1.
  - Even c: KEY_CLK=0, KEY_OUT ← {KEY_OUT[KEY_W−2:0], CORE_DATA[sel]}.
  - Odd c: KEY_CLK=1.
  - After c=2·KEY_W−1, go to PRESENT with KEY_CLK=0.
- PRESENT: KEY_VALID=1; KEY_OUT and KEY_SRC are stable. On KEY_VALID&KEY_READY: HIT_CNT+1 (saturating), pointer ← sel+1 mod NCORES, go to ACK.
- ACK: CORE_ACK[sel]=1 for one cycle.
  - MODE_ALL=0: go to FINISH.
  - MODE_ALL=1: go to HOLD.
- HOLD: one-cycle settle while the acked core drops CORE_VALID; then SEARCH.
- FINISH: DONE=1, CORE_RUN=0. START here restarts exactly as from IDLE.
- START outside IDLE/FINISH is ignored. STREAM changes outside an accepted START have no effect.
- CORE_VALID deasserting during SHIFT is a core protocol violation; the shift completes regardless.

## Timing
- Reset values: all outputs 0, state IDLE, pointer 0. Reset mid-search drops CORE_RUN and KEY_VALID on the next edge with no CORE_ACK pulse.
- START accepted at edge t: CORE_RUN=1 and BUSY=1 from t+1.
- CORE_VALID first sampled in SEARCH at edge t: GRANT at t+1, SHIFT during t+2..t+2+2·KEY_W−1, KEY_VALID=1 at t+2+2·KEY_W (t+98 for KEY_W=48).
- KEY_VALID&KEY_READY at edge u: CORE_ACK pulse during u+1. MODE_ALL=1: SEARCH at u+3. MODE_ALL=0: DONE=1 at u+2.
- KEY_READY held high before KEY_VALID gives single-cycle PRESENT.
- All-done with no valid, sampled at edge t: DONE=1 from t+1.

## Structure
- Package crypto1_pkg: state enum, and the default key/stream widths shared with the cores.
- Sub-module crypto1_rr_arbiter, parametrised by N: request vector + pointer in, one-hot grant + encoded index + any out, purely combinational. The controller registers the encoded index.

## Test plan
- Single hit, NCORES=4, MODE_ALL=0: core 2 holds key 0x27568d75631f, KEY_READY=1 → KEY_VALID at t+98 with KEY_OUT=0x27568d75631f, KEY_SRC=2; CORE_ACK=4'b0100 for one cycle; DONE=1; HIT_CNT=1.
- No hit: all CORE_DONE rise, no valid → DONE=1 next cycle, HIT_CNT=0, KEY_VALID never high.
- Round-robin, MODE_ALL=1: cores 0, 1 and 3 valid simultaneously → keys presented in order 0, 1, 3; then DONE once all cores are done; HIT_CNT=3.
- Backpressure: KEY_READY low for 20 cycles after KEY_VALID → KEY_OUT and KEY_SRC stable, no CORE_ACK until the handshake.
- Simultaneous: CORE_VALID[1] and &CORE_DONE rise in the same cycle → core 1 is serviced before DONE.
- Reset mid-SHIFT at c=30, then START → all outputs 0 after reset; the new search returns the correct key with HIT_CNT restarted from 0.
